frame_packer: RTL and testbench

Streaming input stage that sits directly upstream of the space-to-depth slice stage. It accepts 16-bit activation elements one per beat in channel-major raster order (c, then row, then column) over a valid/ready handshake, assembles one complete W×H×K tensor into a flat register bus, and presents that bus to the slice stage. The bus is held stable until the slice stage consumes it with its own valid/ready handshake. The block is single-buffered: filling and presenting never overlap.

---
 rtl/frame_packer_if.sv | 42 ++++
 rtl/frame_packer.sv | 119 +++++++++++
 tb/tb_frame_packer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_packer_if.sv
// Handshake bundle linking the element stream, frame_packer and the slice stage.
// in_last/err exist only when FRAME_PACKER_LAST_CHECK_EN is defined.
interface frame_packer_if #(
    parameter int unsigned W = 4,
    parameter int unsigned H = 4,
    parameter int unsigned K = 3
);
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned N          = W * H * K;

    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [0:N*DATA_WIDTH-1] out_frame;
    logic                    out_valid;
    logic                    out_ready;

`ifdef FRAME_PACKER_LAST_CHECK_EN
    logic in_last;
    logic err;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_frame, out_valid, err
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_frame, out_valid, err
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_frame, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_frame, out_valid
    );
`endif
endinterface

// File: rtl/frame_packer.sv
// Single-buffered W x H x K tensor assembler feeding the space-to-depth slice stage.
// Optional framing check on in_last enabled by FRAME_PACKER_LAST_CHECK_EN.
module frame_packer #(
    parameter int unsigned W = 4,
    parameter int unsigned H = 4,
    parameter int unsigned K = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    frame_packer_if.slave bus
);
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned N          = W * H * K;
    localparam int unsigned IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic                  armed_q;
    logic                  in_rdy;
    logic                  out_vld;
    logic                  accept;
    logic [DATA_WIDTH-1:0] mem_q [N];

`ifdef FRAME_PACKER_LAST_CHECK_EN
    logic err_q;
    logic err_d;
`endif

    assign accept = bus.in_valid && in_rdy;

    // armed_q keeps in_ready low for the cycle right after a reset edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            armed_q <= 1'b0;
`ifdef FRAME_PACKER_LAST_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            armed_q <= 1'b1;
`ifdef FRAME_PACKER_LAST_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef FRAME_PACKER_LAST_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = HOLD;
                        idx_d   = '0;
`ifdef FRAME_PACKER_LAST_CHECK_EN
                        if (!bus.in_last) err_d = 1'b1;
                    end else if (bus.in_last) begin
                        // early last: keep the beat, drop the partial frame
                        idx_d = '0;
                        err_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = FILL;
            end
        endcase
    end

    // handshake outputs decode registered state only
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            FILL: in_rdy  = armed_q;
            HOLD: out_vld = 1'b1;
        endcase
    end

    // slots are overwritten in place, no clear between frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < int'(N); e++) begin
                mem_q[IDX_W'(e)] <= '0;
            end
        end else if (accept) begin
            mem_q[idx_q] <= bus.in_data;
        end
    end

    for (genvar e = 0; e < int'(N); e++) begin : g_pack
        assign bus.out_frame[e*DATA_WIDTH +: DATA_WIDTH] = mem_q[e];
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
`ifdef FRAME_PACKER_LAST_CHECK_EN
    assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_frame_packer.sv
// Scoreboard bench for frame_packer: a reference model queues each expected frame,
// a monitor compares every presented frame and its hold behaviour.
module tb_frame_packer;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned K  = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned N  = W * H * K;
    localparam int unsigned FB = N * DW;
    localparam int unsigned IW = $clog2(N);
`ifdef FRAME_PACKER_LAST_CHECK_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_packer_if #(.W(W), .H(H), .K(K)) bus();

    frame_packer #(.W(W), .H(H), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] m_mem [N];
    logic [IW-1:0] m_idx;
    bit            m_err;
    logic [0:FB-1] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [0:FB-1] got, input logic [0:FB-1] want);
        int bad;
        bad = -1;
        for (int e = 0; e < int'(N); e++) begin
            if (bad < 0 && got[e*DW +: DW] !== want[e*DW +: DW]) bad = e;
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: element %0d got 0x%0h want 0x%0h (cycle %0d)",
                     nm, bad, got[bad*DW +: DW], want[bad*DW +: DW], cyc);
        end
    endtask

    function automatic logic [0:FB-1] pack_model();
        logic [0:FB-1] r;
        for (int e = 0; e < int'(N); e++) r[e*DW +: DW] = m_mem[IW'(e)];
        return r;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < int'(N); e++) m_mem[IW'(e)] = '0;
        m_idx = '0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input bit l);
        m_mem[m_idx] = d;
        if (m_idx == IW'(N - 1)) begin
            exp_q.push_back(pack_model());
            m_idx = '0;
            if (LAST_EN && !l) m_err = 1'b1;
        end else if (LAST_EN && l) begin
            m_idx = '0;
            m_err = 1'b1;
        end else begin
            m_idx = m_idx + IW'(1);
        end
    endtask

    // Drive one element at a negedge and hold it until it is taken.
    task automatic beat(input logic [DW-1:0] d, input bit l, output int stalls);
        stalls = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
`ifdef FRAME_PACKER_LAST_CHECK_EN
        bus.in_last  = l;
`endif
        while (bus.in_ready !== 1'b1 && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 100) chk("accept_timeout", 32'(bus.in_ready), 32'h1);
        else               model_accept(d, l);
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifdef FRAME_PACKER_LAST_CHECK_EN
        bus.in_last  = 1'b0;
`endif
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit last_on, input bit bubbles,
                              output int first_stall);
        int st;
        first_stall = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = DW'($urandom);
                @(negedge clk);
            end
            beat(base + DW'(i), last_on && (i == int'(N) - 1), st);
            if (i == 0) first_stall = st;
        end
        chk("valid_after_last", 32'(bus.out_valid), 32'h1);
        chk("ready_after_last", 32'(bus.in_ready), 32'h0);
    endtask

    task automatic release_frame();
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("present_timeout", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_after_take", 32'(bus.out_valid), 32'h0);
        chk("ready_after_take", 32'(bus.in_ready), 32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk_frame("reset_frame", bus.out_frame, '0);
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_ready", 32'(bus.in_ready), 32'h0);
`ifdef FRAME_PACKER_LAST_CHECK_EN
        chk("reset_err", 32'(bus.err), 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.in_ready), 32'h1);
    endtask

    // Monitor: pop on each new presentation, then police the hold.
    bit            presenting = 1'b0;
    logic [0:FB-1] held;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (!presenting) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(exp_q.size()), 32'h1);
                end else begin
                    chk_frame("frame", bus.out_frame, exp_q.pop_front());
                end
                held       = bus.out_frame;
                presenting = 1'b1;
            end else begin
                chk_frame("hold_stable", bus.out_frame, held);
                chk("hold_ready", 32'(bus.in_ready), 32'h0);
            end
        end else begin
            presenting = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at cycle %0d, limit 20000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, st2;
        int unsigned c1, c2;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef FRAME_PACKER_LAST_CHECK_EN
        bus.in_last   = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // contiguous fill 0x0000..0x002F
        send_frame(16'h0000, 1'b1, 1'b0, st);
        chk("elem0", 32'(bus.out_frame[0 +: DW]), 32'h0000);
        chk("elem47", 32'(bus.out_frame[(N-1)*DW +: DW]), 32'h002F);

        // backpressure: garbage offered while held
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("valid_under_bp", 32'(bus.out_valid), 32'h1);
        release_frame();

        // random bubbles
        send_frame(16'h1000, 1'b1, 1'b1, st);
        release_frame();

        // back-to-back with out_ready tied high
        bus.out_ready = 1'b1;
        send_frame(16'h2000, 1'b1, 1'b0, st);
        c1 = cyc;
        send_frame(16'h3000, 1'b1, 1'b0, st2);
        c2 = cyc;
        chk("b2b_stall", 32'(st2), 32'h1);
        chk("b2b_period", c2 - c1, 32'd49);
        @(negedge clk);
        chk("b2b_drop", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // reset after 20 beats, then a clean frame
        for (int i = 0; i < 20; i++) beat(16'h4000 + DW'(i), 1'b0, st);
        do_reset();
        send_frame(16'h5000, 1'b1, 1'b0, st);
        release_frame();

`ifdef FRAME_PACKER_LAST_CHECK_EN
        // early last on beat 10
        for (int i = 0; i <= 10; i++) beat(16'h6000 + DW'(i), i == 10, st);
        chk("early_err", 32'(bus.err), 32'(m_err));
        repeat (3) @(negedge clk);
        chk("early_no_valid", 32'(bus.out_valid), 32'h0);
        send_frame(16'h7000, 1'b1, 1'b0, st);
        chk("err_sticky", 32'(bus.err), 32'(m_err));
        release_frame();
        do_reset();
        // missing last on beat 47
        send_frame(16'h8000, 1'b0, 1'b0, st);
        chk("missing_err", 32'(bus.err), 32'(m_err));
        release_frame();
`endif

        repeat (3) @(negedge clk);
        chk("pending_frames", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
